// File: rtl/serial_word_adder_pkg.sv
// Shared types and sizing helpers for the word-serial adder.
// Included by the sequencer top and its bench.
package serial_word_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   function automatic int n_words(input int data_w, input int word_w);
      return data_w / word_w;
   endfunction

   // Counter is at least one bit wide so a single-word build still has a legal vector.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/word_full_adder_chain.sv
// Combinational WIDTH-bit a+b+ci built as a ripple of 1-bit full adders.
module word_full_adder_chain #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_ci,
   output logic [WIDTH-1:0] o_s,
   output logic             o_co
);

   logic [WIDTH:0] w_c;

   assign w_c[0] = i_ci;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_co = w_c[WIDTH];

endmodule

// File: rtl/serial_word_adder.sv
// Wide adder that feeds one word per cycle, LSW first, through a single word adder,
// with the word carry registered between cycles and valid/ready on both sides.
module serial_word_adder
   import serial_word_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int WORD_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_ci,
   input  logic                  in_vld,
   output logic                  in_rd,
   output logic [DATA_WIDTH-1:0] out_s,
   output logic                  out_co,
   output logic                  out_vld,
   input  logic                  out_rd
);

   localparam int N_WORDS = n_words(DATA_WIDTH, WORD_WIDTH);
   localparam int CNT_W   = cnt_width(N_WORDS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

   state_t r_state;
   state_t w_next;

   logic [N_WORDS-1:0][WORD_WIDTH-1:0] r_a;
   logic [N_WORDS-1:0][WORD_WIDTH-1:0] r_b;
   logic [N_WORDS-1:0][WORD_WIDTH-1:0] r_s;
   logic                               r_carry;
   logic                               r_co;
   logic [CNT_W-1:0]                   r_cnt;

   logic [WORD_WIDTH-1:0] w_sum;
   logic                  w_co;
   logic                  w_last;
   logic                  w_accept;

   word_full_adder_chain #(
      .WIDTH (WORD_WIDTH)
   ) u_word_add (
      .i_a  (r_a[r_cnt]),
      .i_b  (r_b[r_cnt]),
      .i_ci (r_carry),
      .o_s  (w_sum),
      .o_co (w_co)
   );

   assign w_last   = (r_cnt == LAST_CNT);
   assign w_accept = in_vld & in_rd;

   always_comb begin
      w_next  = r_state;
      in_rd   = 1'b0;
      out_vld = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_rd = 1'b1;
            if (in_vld) w_next = S_RUN;
         end
         S_RUN: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            // A new operand set may ride in on the same cycle the result leaves.
            in_rd   = out_rd;
            out_vld = 1'b1;
            if (out_rd) w_next = in_vld ? S_RUN : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_co    <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= in_a;
         r_b     <= in_b;
         r_carry <= in_ci;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_s[r_cnt] <= w_sum;
         r_carry    <= w_co;
         // Counter parks on the last word; only a new accept rewinds it.
         if (w_last) r_co  <= w_co;
         else        r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out_s  = r_s;
   assign out_co = r_co;

endmodule
